// File: rtl/cpu_interrupt_controller.sv
// cpu_interrupt_controller
// Interrupt and reset sequencer for the 6502 core. Detects NMI falling edges,
// qualifies multi-source active-low IRQ levels against per-source enables and
// the P register I flag, and presents one prioritised request (RESET > NMI >
// IRQ) to the Decoder together with the matching vector address.
//
// Ports:
//   i_clk          clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_nmi_n        NMI, falling-edge sensitive
//   i_irq_n        IRQ sources, active-low level
//   i_irq_enable   per-source IRQ enable mask
//   i_flag_i       P register I flag, 1 masks all IRQ
//   i_sync         instruction boundary (qualified by the Decoder)
//   i_ack          Decoder starts the interrupt sequence
//   i_vector_rd    Decoder fetches the vector low byte this cycle
//   o_interrupt    registered request to Decoder/IR (force BRK)
//   o_kind         registered kind: 0 NONE, 1 IRQ, 2 NMI, 3 RESET
//   o_vector_addr  registered vector for o_kind (0 when NONE)
//   o_irq_pending  registered ~i_irq_n & i_irq_enable
//   o_nmi_pending  NMI edge latched, not yet serviced
//
// Configuration macro: CPU_INTCTL_SYNC_EN adds two-flop synchronisers on
// i_nmi_n and each i_irq_n bit (reset to 1), adding 2 cycles of latency.

module cpu_interrupt_controller #(
    parameter int unsigned           NUM_IRQ     = 4,
    parameter int unsigned           ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] VECTOR_BASE = 16'hFFFA
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_nmi_n,
    input  logic [NUM_IRQ-1:0]    i_irq_n,
    input  logic [NUM_IRQ-1:0]    i_irq_enable,
    input  logic                  i_flag_i,
    input  logic                  i_sync,
    input  logic                  i_ack,
    input  logic                  i_vector_rd,
    output logic                  o_interrupt,
    output logic [1:0]            o_kind,
    output logic [ADDR_WIDTH-1:0] o_vector_addr,
    output logic [NUM_IRQ-1:0]    o_irq_pending,
    output logic                  o_nmi_pending
);

    localparam logic [1:0] KIND_NONE  = 2'd0;
    localparam logic [1:0] KIND_IRQ   = 2'd1;
    localparam logic [1:0] KIND_NMI   = 2'd2;
    localparam logic [1:0] KIND_RESET = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] VEC_NMI   = VECTOR_BASE;
    localparam logic [ADDR_WIDTH-1:0] VEC_RESET = VECTOR_BASE + ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] VEC_IRQ   = VECTOR_BASE + ADDR_WIDTH'(4);

    typedef enum logic [1:0] {
        RESET_PEND = 2'd0,
        IDLE       = 2'd1,
        REQUEST    = 2'd2,
        SERVICE    = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic                    int_q, int_d;
    logic [1:0]              kind_q, kind_d;
    logic [ADDR_WIDTH-1:0]   vec_q, vec_d;
    logic [NUM_IRQ-1:0]      irq_pend_q, irq_pend_d;
    logic                    nmi_pend_q, nmi_pend_d;
    logic                    nmi_prev_q;

    logic                    nmi_s;
    logic [NUM_IRQ-1:0]      irq_s;
    logic                    nmi_edge;
    logic                    nmi_clear;
    logic                    irq_req;
    logic                    any_req;
    logic [1:0]              req_kind;

    // Boundary qualification happens in the Decoder, which samples our outputs on i_sync.
    logic unused_sync;
    assign unused_sync = i_sync;

`ifdef CPU_INTCTL_SYNC_EN
    // Two-flop synchronisers; idle-high so reset never fakes an edge or level.
    logic [1:0]         nmi_sync_q;
    logic [NUM_IRQ-1:0] irq_sync1_q, irq_sync2_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            nmi_sync_q  <= 2'b11;
            irq_sync1_q <= '1;
            irq_sync2_q <= '1;
        end else begin
            nmi_sync_q  <= {nmi_sync_q[0], i_nmi_n};
            irq_sync1_q <= i_irq_n;
            irq_sync2_q <= irq_sync1_q;
        end
    end

    assign nmi_s = nmi_sync_q[1];
    assign irq_s = irq_sync2_q;
`else
    assign nmi_s = i_nmi_n;
    assign irq_s = i_irq_n;
`endif

    // Vector address for a given kind.
    function automatic logic [ADDR_WIDTH-1:0] vec_of(input logic [1:0] kind);
        case (kind)
            KIND_NMI:   vec_of = VEC_NMI;
            KIND_RESET: vec_of = VEC_RESET;
            KIND_IRQ:   vec_of = VEC_IRQ;
            default:    vec_of = '0;
        endcase
    endfunction

    // Request qualification; a new edge in the clearing cycle wins over the clear.
    always_comb begin
        nmi_edge   = nmi_prev_q & ~nmi_s;
        nmi_clear  = (state_q == SERVICE) & i_vector_rd & (kind_q == KIND_NMI);
        nmi_pend_d = nmi_edge | (nmi_pend_q & ~nmi_clear);
        irq_pend_d = ~irq_s & i_irq_enable;
        irq_req    = (|irq_pend_q) & ~i_flag_i;
        any_req    = nmi_pend_q | irq_req;
        req_kind   = nmi_pend_q ? KIND_NMI : KIND_IRQ;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        int_d   = int_q;
        kind_d  = kind_q;
        case (state_q)
            RESET_PEND: begin
                int_d  = 1'b1;
                kind_d = KIND_RESET;
                if (i_ack) begin
                    state_d = SERVICE;
                    int_d   = 1'b0;
                end
            end
            IDLE: begin
                int_d  = 1'b0;
                kind_d = KIND_NONE;
                if (any_req) begin
                    state_d = REQUEST;
                    int_d   = 1'b1;
                    kind_d  = req_kind;
                end
            end
            REQUEST: begin
                // A request withdrawn before ack is dropped rather than serviced as NONE.
                if (!any_req) begin
                    state_d = IDLE;
                    int_d   = 1'b0;
                    kind_d  = KIND_NONE;
                end else begin
                    int_d  = 1'b1;
                    kind_d = req_kind;
                    if (i_ack) begin
                        state_d = SERVICE;
                        int_d   = 1'b0;
                    end
                end
            end
            SERVICE: begin
                int_d = 1'b0;
                if (i_vector_rd) begin
                    state_d = IDLE;
                    kind_d  = KIND_NONE;
                end else if (kind_q == KIND_IRQ && nmi_pend_q) begin
                    // NMI hijacks an IRQ sequence that has not yet fetched its vector.
                    kind_d = KIND_NMI;
                end
            end
            default: begin
                state_d = IDLE;
                int_d   = 1'b0;
                kind_d  = KIND_NONE;
            end
        endcase
        vec_d = vec_of(kind_d);
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= RESET_PEND;
            int_q      <= 1'b1;
            kind_q     <= KIND_RESET;
            vec_q      <= VEC_RESET;
            irq_pend_q <= '0;
            nmi_pend_q <= 1'b0;
            nmi_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            int_q      <= int_d;
            kind_q     <= kind_d;
            vec_q      <= vec_d;
            irq_pend_q <= irq_pend_d;
            nmi_pend_q <= nmi_pend_d;
            nmi_prev_q <= nmi_s;
        end
    end

    assign o_interrupt   = int_q;
    assign o_kind        = kind_q;
    assign o_vector_addr = vec_q;
    assign o_irq_pending = irq_pend_q;
    assign o_nmi_pending = nmi_pend_q;

endmodule

// File: tb/tb_cpu_interrupt_controller.sv
// Testbench for cpu_interrupt_controller: directed scenarios followed by
// random traffic, every cycle compared against a behavioural model.

module tb_cpu_interrupt_controller;

    localparam int unsigned NI = 4;
    localparam int unsigned AW = 16;

    // Model phases.
    localparam int PH_WAIT_RESET = 0;
    localparam int PH_IDLE       = 1;
    localparam int PH_ASKING     = 2;
    localparam int PH_SERVING    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          nmi_n;
    logic [NI-1:0] irq_n;
    logic [NI-1:0] irq_en;
    logic          flag_i;
    logic          sync;
    logic          ack;
    logic          vrd;
    logic          o_int;
    logic [1:0]    o_kind;
    logic [AW-1:0] o_vec;
    logic [NI-1:0] o_irqp;
    logic          o_nmip;

    int checks = 0;
    int errors = 0;

    // Model state.
    int            m_phase;
    bit            m_int;
    int            m_kind;
    bit            m_nmi_prev;
    bit            m_nmi_pend;
    bit [NI-1:0]   m_irq_pend;

    cpu_interrupt_controller #(.NUM_IRQ(NI), .ADDR_WIDTH(AW), .VECTOR_BASE(16'hFFFA)) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_nmi_n       (nmi_n),
        .i_irq_n       (irq_n),
        .i_irq_enable  (irq_en),
        .i_flag_i      (flag_i),
        .i_sync        (sync),
        .i_ack         (ack),
        .i_vector_rd   (vrd),
        .o_interrupt   (o_int),
        .o_kind        (o_kind),
        .o_vector_addr (o_vec),
        .o_irq_pending (o_irqp),
        .o_nmi_pending (o_nmip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Vector table: NMI at base, RESET at base+2, IRQ at base+4, none is 0.
    function automatic logic [31:0] exp_vec(input int kind);
        case (kind)
            2:       exp_vec = 32'(16'(16'hFFFA + 16'd0));
            3:       exp_vec = 32'(16'(16'hFFFA + 16'd2));
            1:       exp_vec = 32'(16'(16'hFFFA + 16'd4));
            default: exp_vec = 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_phase    = PH_WAIT_RESET;
        m_int      = 1'b1;
        m_kind     = 3;
        m_nmi_prev = 1'b1;
        m_nmi_pend = 1'b0;
        m_irq_pend = '0;
    endtask

    // One clock of the behavioural model, using the inputs present at the edge.
    task automatic model_step();
        bit want_nmi, want_irq, serviced_nmi;
        want_nmi     = m_nmi_pend;
        want_irq     = (m_irq_pend != '0) && !flag_i;
        serviced_nmi = 1'b0;
        case (m_phase)
            PH_WAIT_RESET: if (ack) begin m_phase = PH_SERVING; m_int = 1'b0; end
            PH_IDLE: if (want_nmi || want_irq) begin
                m_phase = PH_ASKING; m_int = 1'b1; m_kind = want_nmi ? 2 : 1;
            end
            PH_ASKING: begin
                if (!(want_nmi || want_irq)) begin
                    m_phase = PH_IDLE; m_int = 1'b0; m_kind = 0;
                end else begin
                    m_kind = want_nmi ? 2 : 1;
                    if (ack) begin m_phase = PH_SERVING; m_int = 1'b0; end
                end
            end
            default: begin
                if (vrd) begin
                    serviced_nmi = (m_kind == 2);
                    m_phase = PH_IDLE; m_kind = 0;
                end else if (m_kind == 1 && want_nmi) begin
                    m_kind = 2;
                end
            end
        endcase
        m_nmi_pend = (m_nmi_prev && !nmi_n) || (m_nmi_pend && !serviced_nmi);
        m_irq_pend = ~irq_n & irq_en;
        m_nmi_prev = nmi_n;
    endtask

    task automatic check_model(input string where);
        chk({where, ".int"},  32'(o_int),  32'(m_int));
        chk({where, ".kind"}, 32'(o_kind), 32'(m_kind));
        chk({where, ".vec"},  32'(o_vec),  exp_vec(m_kind));
        chk({where, ".irqp"}, 32'(o_irqp), 32'(m_irq_pend));
        chk({where, ".nmip"}, 32'(o_nmip), 32'(m_nmi_pend));
    endtask

    // Advance one cycle; outputs are sampled on the falling edge.
    task automatic tick(input string where);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model(where);
    endtask

    task automatic check_reset_values(input string where);
        chk({where, ".int"},  32'(o_int),  32'd1);
        chk({where, ".kind"}, 32'(o_kind), 32'd3);
        chk({where, ".vec"},  32'(o_vec),  32'h0000_FFFC);
        chk({where, ".irqp"}, 32'(o_irqp), 32'd0);
        chk({where, ".nmip"}, 32'(o_nmip), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; nmi_n = 1'b1; irq_n = '1; irq_en = '0;
        flag_i = 1'b1; sync = 1'b0; ack = 1'b0; vrd = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_values("in_reset");
        rst_n = 1'b1;

        // Reset request, ack, vector fetch.
        tick("rst_hold");
        chk("rst_req_vec", 32'(o_vec), 32'h0000_FFFC);
        ack = 1'b1; tick("rst_ack"); ack = 1'b0;
        chk("rst_ack_int", 32'(o_int), 32'd0);
        vrd = 1'b1; tick("rst_vrd"); vrd = 1'b0;
        chk("rst_done_kind", 32'(o_kind), 32'd0);
        chk("rst_done_int", 32'(o_int), 32'd0);

        // NMI held low: exactly one service.
        nmi_n = 1'b0; tick("nmi_edge");
        chk("nmi_pend_set", 32'(o_nmip), 32'd1);
        tick("nmi_req");
        chk("nmi_req_int", 32'(o_int), 32'd1);
        chk("nmi_req_vec", 32'(o_vec), 32'h0000_FFFA);
        ack = 1'b1; tick("nmi_ack"); ack = 1'b0;
        vrd = 1'b1; tick("nmi_vrd"); vrd = 1'b0;
        chk("nmi_cleared", 32'(o_nmip), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick("nmi_held");
            chk("nmi_no_retrigger", 32'(o_int), 32'd0);
        end
        nmi_n = 1'b1; tick("nmi_high");
        nmi_n = 1'b0; tick("nmi_edge2");
        tick("nmi_req2");
        chk("nmi_req2_int", 32'(o_int), 32'd1);
        ack = 1'b1; tick("nmi_ack2"); ack = 1'b0;
        vrd = 1'b1; tick("nmi_vrd2"); vrd = 1'b0;
        nmi_n = 1'b1; tick("nmi_release");

        // Masked IRQ source, then I flag withdraws the request.
        irq_n = 4'b1101; irq_en = 4'b0010; flag_i = 1'b0;
        tick("irq_sample");
        chk("irq_pending", 32'(o_irqp), 32'h2);
        tick("irq_req");
        chk("irq_req_int", 32'(o_int), 32'd1);
        chk("irq_req_vec", 32'(o_vec), 32'h0000_FFFE);
        flag_i = 1'b1; tick("irq_masked");
        chk("irq_masked_int", 32'(o_int), 32'd0);
        chk("irq_masked_kind", 32'(o_kind), 32'd0);
        tick("irq_masked_idle");

        // NMI hijacks an acknowledged IRQ.
        flag_i = 1'b0; tick("hj_req");
        ack = 1'b1; tick("hj_ack"); ack = 1'b0;
        chk("hj_service_kind", 32'(o_kind), 32'd1);
        nmi_n = 1'b0; tick("hj_edge");
        tick("hj_upgrade");
        chk("hj_kind", 32'(o_kind), 32'd2);
        chk("hj_vec", 32'(o_vec), 32'h0000_FFFA);
        vrd = 1'b1; tick("hj_vrd"); vrd = 1'b0;
        chk("hj_nmi_cleared", 32'(o_nmip), 32'd0);
        flag_i = 1'b1; tick("hj_mask");
        nmi_n = 1'b1; tick("hj_nmi_high");

        // Simultaneous NMI edge and IRQ: NMI first, then IRQ.
        irq_n = '1; tick("sim_drop"); tick("sim_drop2");
        flag_i = 1'b0; nmi_n = 1'b0; irq_n = 4'b1101; tick("sim_both");
        tick("sim_req");
        chk("sim_first_kind", 32'(o_kind), 32'd2);
        ack = 1'b1; tick("sim_ack"); ack = 1'b0;
        vrd = 1'b1; tick("sim_vrd"); vrd = 1'b0;
        tick("sim_req2");
        chk("sim_second_kind", 32'(o_kind), 32'd1);
        chk("sim_second_vec", 32'(o_vec), 32'h0000_FFFE);
        nmi_n = 1'b1;

        // Async reset during SERVICE with NMI pending.
        ack = 1'b1; tick("ar_ack"); ack = 1'b0;
        nmi_n = 1'b0; tick("ar_edge");
        chk("ar_pend_before", 32'(o_nmip), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        model_reset();
        nmi_n = 1'b1; irq_n = '1; flag_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) nmi_n = ~nmi_n;
            if ($urandom_range(0, 7) == 0) irq_n = NI'($urandom);
            if ($urandom_range(0, 15) == 0) irq_en = NI'($urandom);
            flag_i = ($urandom_range(0, 3) == 0);
            ack    = ($urandom_range(0, 2) == 0);
            vrd    = ($urandom_range(0, 2) == 0);
            sync   = ($urandom_range(0, 1) == 0);
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_interrupt_controller.md
# cpu_interrupt_controller

Parametrised interrupt and reset sequencer for the 6502 core. It replaces the single hard-wired interrupt line between Decoder and IR with three things: NMI edge detection, multi-source maskable IRQ, and a post-reset RESET request. It presents one prioritised request to the Decoder at instruction boundaries and supplies the vector address for the sequence. It sits beside TCU/Decoder and drives the IR force-BRK input.

## Interface
Parameters:
- NUM_IRQ, 4: number of active-low level IRQ sources (1..8).
- ADDR_WIDTH, 16: vector address width.
- VECTOR_BASE, 16'hFFFA: NMI vector address. RESET is VECTOR_BASE+2; IRQ is VECTOR_BASE+4.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_nmi_n  in  1  NMI, falling-edge sensitive.
- i_irq_n  in  NUM_IRQ  IRQ sources, active-low level.
- i_irq_enable  in  NUM_IRQ  per-source enable mask.
- i_flag_i  in  1  P register I flag; 1 masks all IRQ.
- i_sync  in  1  instruction boundary (opcode fetch cycle).
- i_ack  in  1  Decoder starts the interrupt sequence.
- i_vector_rd  in  1  Decoder fetches vector low byte this cycle.
- o_interrupt  out  1  request to Decoder/IR (force BRK opcode).
- o_kind  out  2  0 NONE, 1 IRQ, 2 NMI, 3 RESET.
- o_vector_addr  out  ADDR_WIDTH  vector for o_kind (0 when NONE).
- o_irq_pending  out  NUM_IRQ  registered ~i_irq_n & i_irq_enable.
- o_nmi_pending  out  1  NMI edge latched, not yet serviced.

## Operation
- States: RESET_PEND, IDLE, REQUEST, SERVICE.
- Reset values: state RESET_PEND, o_interrupt 1, o_kind 3, o_vector_addr VECTOR_BASE+2, o_irq_pending 0, o_nmi_pending 0. The NMI previous-sample register resets to 1.
- NMI edge: the registered previous sample is 1 and the current sample is 0 → set nmi_pending. A held-low NMI does not retrigger; it must return high first.
- irq_req = |(o_irq_pending) & ~i_flag_i.
- RESET_PEND: hold o_interrupt=1, kind RESET. On i_ack → SERVICE.
- IDLE: if nmi_pending or irq_req → REQUEST, o_interrupt=1, kind NMI if nmi_pending, else IRQ.
- REQUEST: kind is re-evaluated every cycle, with NMI having priority.
  - If neither condition remains (IRQ released or masked before ack), → IDLE with o_interrupt=0.
  - On i_ack → SERVICE, o_interrupt=0.
- SERVICE: kind is held.
  - Hijack: if kind=IRQ and nmi_pending becomes set before i_vector_rd, kind upgrades to NMI.
  - On i_vector_rd: freeze kind/vector for that cycle; clear nmi_pending if kind=NMI. Next cycle → IDLE, kind NONE.
- An NMI edge in the same cycle as an NMI-service i_vector_rd sets pending again; set wins over clear.
- i_ack outside RESET_PEND/REQUEST and i_vector_rd outside SERVICE are ignored.
- Vector arithmetic: VECTOR_BASE + {0,2,4}, truncated to ADDR_WIDTH with wrap.

## Timing
- NMI: edge sampled at cycle n → o_nmi_pending=1 at n+1 → o_interrupt=1 at n+2 (from IDLE).
- IRQ: level sampled at n → o_irq_pending at n+1 → o_interrupt at n+2.
- o_interrupt, o_kind and o_vector_addr are registered. The Decoder samples them when i_sync=1.
- o_interrupt falls the cycle after i_ack. o_kind returns to NONE the cycle after i_vector_rd.
- Async reset mid-sequence: immediate return to reset values; pending NMI is discarded.

## Configuration
- CPU_INTCTL_SYNC_EN defined: two-flop synchronisers on i_nmi_n and each i_irq_n bit, reset to 1. This adds 2 cycles to every latency above (NMI/IRQ → o_interrupt = 4 cycles).
- Undefined: inputs are sampled directly; latencies are as stated in Timing.

## Test plan
- Reset release → o_interrupt=1, o_kind=3, o_vector_addr=16'hFFFC. i_ack, then i_vector_rd → o_kind=0, o_interrupt=0.
- i_nmi_n 1→0 held low 20 cycles, full ack/vector_rd cycle → exactly one NMI service, vector 16'hFFFA; no second request until NMI goes high then low.
- i_irq_n=4'b1101, enable=4'b0010, i_flag_i=0 → o_irq_pending=4'b0010, o_interrupt=1, vector 16'hFFFE. Then set i_flag_i=1 before ack → o_interrupt=0, state IDLE.
- IRQ acked (SERVICE, kind 1), NMI edge before i_vector_rd → o_kind=2, o_vector_addr=16'hFFFA at i_vector_rd; o_nmi_pending cleared after.
- Simultaneous NMI edge and IRQ in IDLE → kind NMI serviced first; IRQ still held → second request, kind IRQ, vector 16'hFFFE.
- Assert i_reset_n=0 during SERVICE with NMI pending → outputs immediately at reset values, o_nmi_pending=0.
